// File: rtl/spi_pkg.sv
// Shared types for the oversampled SPI slave: the control-state enum and the
// helper that picks which sclk polarity transition is the sample edge.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    WAIT  = 2'd3
  } state_t;

  // Leading edge is the move away from CPOL; CPHA=0 samples on it, CPHA=1 on
  // the trailing edge. Returns 1 when the sample edge is a rising sclk edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return ~(cpol ^ cpha);
  endfunction

endpackage

// File: rtl/spi_slave_sync_sync2.sv
// Two-flop synchroniser bank with a configurable reset value per bit.
module sync2
#(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops bring the asynchronous pins into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave running entirely on the system clock. sclk/ss/mosi are
// oversampled, all four CPOL/CPHA modes and any WIDTH in 2..32 are supported,
// and words stream back to back while ss stays high.
// Optional status outputs (underrun, abort, status_clr, frame_count) are
// built when SPI_SLAVE_SYNC_STATUS_EN is defined.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
`ifdef SPI_SLAVE_SYNC_STATUS_EN
  ,
  output logic             underrun,
  output logic             abort,
  input  logic             status_clr,
  output logic [15:0]      frame_count
`endif
);

  localparam int CW          = $clog2(WIDTH + 1);
  localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

  // First bit of a word on the wire, depending on bit order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Drop the bit just presented and move the next one to the head.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  logic sclk_s, ss_s, mosi_s;

  sync2 #(
    .W       (3),
    .RST_VAL ({CPOL, 1'b0, 1'b0})
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({sclk, ss, mosi}),
    .q   ({sclk_s, ss_s, mosi_s})
  );

  // ---- edge-detect stage: strobes, mosi and ss all land together ----
  logic sclk_d, sample_p, shift_p, mosi_p;
  logic sclk_rise, sclk_fall;

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  // Register one-cycle sample/shift strobes and align mosi/ss with them.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_d   <= CPOL;
      sample_p <= 1'b0;
      shift_p  <= 1'b0;
      mosi_p   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      sclk_d   <= sclk_s;
      sample_p <= SAMPLE_RISE ? sclk_rise : sclk_fall;
      shift_p  <= SAMPLE_RISE ? sclk_fall : sclk_rise;
      mosi_p   <= mosi_s;
      busy     <= ss_s;
    end
  end

  // ---- control stage: word framing, shifters and tx holding register ----
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tx_sh;
  logic [WIDTH-1:0] rx_sh;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] load_word;
  logic [1:0]       settle;
  logic             fresh;

  assign rx_next   = MSB_FIRST ? {rx_sh[WIDTH-2:0], mosi_p}
                               : {mosi_p, rx_sh[WIDTH-1:1]};
  // tx_ready high means the holding register is empty: send all-ones.
  assign load_word = tx_ready ? '1 : hold;

  // Main FSM: frames words on the strobes and owns the tx handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WAIT;
      settle   <= 2'd0;
      fresh    <= 1'b0;
      cnt      <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      hold     <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b1;
      miso     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      // busy is only trustworthy once the reset values have flushed out
      if (settle != 2'd3) settle <= settle + 2'd1;

      case (state)
        WAIT: begin
          if (settle == 2'd3 && !busy) state <= IDLE;
        end

        IDLE: begin
          if (busy) begin
            state <= LOAD;
            fresh <= 1'b1;
          end
        end

        LOAD: begin
          if (!busy) begin
            state <= IDLE;
          end else begin
            tx_ready <= 1'b1;
            cnt      <= '0;
            fresh    <= 1'b0;
            state    <= SHIFT;
            // With CPHA=0 the first bit must be on the wire before the first
            // sample edge. In a stream the previous word's trailing edge
            // presents it instead, so only a fresh frame drives it here.
            if (!CPHA && fresh) begin
              miso  <= head_bit(load_word);
              tx_sh <= advance(load_word);
            end else begin
              tx_sh <= load_word;
            end
          end
        end

        SHIFT: begin
          if (!busy) begin
            state <= IDLE;
          end else if (sample_p) begin
            rx_sh <= rx_next;
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
              state    <= LOAD;
            end
          end else if (shift_p) begin
            miso  <= head_bit(tx_sh);
            tx_sh <= advance(tx_sh);
          end
        end

        default: state <= IDLE;
      endcase

      // Holding register accepts a word whenever it is empty.
      if (tx_valid && tx_ready) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_SYNC_STATUS_EN
  logic underrun_set, abort_set;

  assign underrun_set = (state == LOAD) && busy && tx_ready;
  assign abort_set    = (state == SHIFT) && !busy && (cnt != '0);

  // Sticky status flags (set beats clear) and a wrapping frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun    <= 1'b0;
      abort       <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      underrun    <= underrun_set | (underrun & ~status_clr);
      abort       <= abort_set | (abort & ~status_clr);
      frame_count <= frame_count + 16'(rx_valid);
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: four WIDTH=8 instances (modes 0..3) and one
// WIDTH=12 LSB-first instance, driven by a bit-banged master. Expected rx
// words go into a queue; a monitor pops and compares on every rx_valid.
module tb_spi_slave_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] sclk_v, ss_v, mosi_v, tx_valid_v;
  wire  [4:0] miso_v, tx_ready_v, rx_valid_v, busy_v;
  logic [7:0] txd [4];
  logic [11:0] txd4;
  wire  [7:0] rxd [4];
  wire  [11:0] rxd4;
`ifdef SPI_SLAVE_SYNC_STATUS_EN
  wire  [4:0] underrun_v, abort_v;
  logic [4:0] status_clr_v;
  wire  [15:0] fcnt_v [5];
`endif

  for (genvar g = 0; g < 4; g++) begin : g_w8
    spi_slave_sync #(
      .WIDTH(8), .CPOL(1'(g / 2)), .CPHA(1'(g % 2)), .MSB_FIRST(1'b1)
    ) dut (
      .clk(clk), .rst(rst), .sclk(sclk_v[g]), .ss(ss_v[g]), .mosi(mosi_v[g]),
      .miso(miso_v[g]), .tx_data(txd[g]), .tx_valid(tx_valid_v[g]),
      .tx_ready(tx_ready_v[g]), .rx_data(rxd[g]), .rx_valid(rx_valid_v[g]),
      .busy(busy_v[g])
`ifdef SPI_SLAVE_SYNC_STATUS_EN
      , .underrun(underrun_v[g]), .abort(abort_v[g]),
      .status_clr(status_clr_v[g]), .frame_count(fcnt_v[g])
`endif
    );
  end

  spi_slave_sync #(
    .WIDTH(12), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0)
  ) dut12 (
    .clk(clk), .rst(rst), .sclk(sclk_v[4]), .ss(ss_v[4]), .mosi(mosi_v[4]),
    .miso(miso_v[4]), .tx_data(txd4), .tx_valid(tx_valid_v[4]),
    .tx_ready(tx_ready_v[4]), .rx_data(rxd4), .rx_valid(rx_valid_v[4]),
    .busy(busy_v[4])
`ifdef SPI_SLAVE_SYNC_STATUS_EN
    , .underrun(underrun_v[4]), .abort(abort_v[4]),
    .status_clr(status_clr_v[4]), .frame_count(fcnt_v[4])
`endif
  );

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] data;
  } rx_exp_t;

  rx_exp_t exp_q[$];
  int checks = 0;
  int passed = 0;

  function automatic logic cpol_of(input int i);
    return (i == 2 || i == 3);
  endfunction
  function automatic logic cpha_of(input int i);
    return (i == 1 || i == 3);
  endfunction
  function automatic int width_of(input int i);
    return (i == 4) ? 12 : 8;
  endfunction
  function automatic logic msb_of(input int i);
    return (i != 4);
  endfunction
  function automatic logic [31:0] rxd_of(input int i);
    if (i == 4) return 32'(rxd4);
    return 32'(rxd[i]);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer one word on the tx port and hold it until the handshake happens.
  task automatic offer(input int i, input logic [31:0] w);
    logic done;
    done = 1'b0;
    @(negedge clk);
    if (i == 4) txd4 = w[11:0];
    else txd[i] = w[7:0];
    tx_valid_v[i] = 1'b1;
    for (int k = 0; k < 3000 && !done; k++) begin
      if (tx_ready_v[i]) done = 1'b1;
      @(negedge clk);
    end
    tx_valid_v[i] = 1'b0;
    chk("tx_offer_accepted", 32'(done), 32'd1);
  endtask

  task automatic ss_set(input int i, input logic v);
    @(negedge clk);
    ss_v[i] = v;
    wait_clk(6);
  endtask

  // Bit-bang nbits of a word in the instance's mode; half sclk period = 5 clk.
  task automatic clock_bits(input int i, input logic [31:0] mo, input int nbits,
                            output logic [31:0] mi);
    logic cpol;
    logic cpha;
    int   idx;
    cpol = cpol_of(i);
    cpha = cpha_of(i);
    mi = '0;
    for (int b = 0; b < nbits; b++) begin
      idx = msb_of(i) ? width_of(i) - 1 - b : b;
      if (!cpha) begin
        mosi_v[i] = mo[idx];
        wait_clk(5);
        sclk_v[i] = ~cpol;
        mi[idx] = miso_v[i];
        wait_clk(5);
        sclk_v[i] = cpol;
      end else begin
        sclk_v[i] = ~cpol;
        mosi_v[i] = mo[idx];
        wait_clk(5);
        sclk_v[i] = cpol;
        mi[idx] = miso_v[i];
        wait_clk(5);
      end
    end
  endtask

  // One complete single-word frame with expected rx and master-read values.
  task automatic xfer(input int i, input logic [31:0] mo, input logic [31:0] exp_rx,
                      input logic [31:0] exp_mi, input string tag);
    logic [31:0] mi;
    exp_q.push_back('{idx: 3'(i), data: exp_rx});
    ss_set(i, 1'b1);
    clock_bits(i, mo, width_of(i), mi);
    wait_clk(6);
    ss_set(i, 1'b0);
    wait_clk(4);
    chk({tag, "_miso"}, mi, exp_mi);
  endtask

  // Scoreboard monitor: every rx_valid pulse must match the queue head.
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rx_valid_v[i]) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL rx_unexpected: dut %0d gave %h, expected no word", i, rxd_of(i));
        end else begin
          rx_exp_t e;
          e = exp_q.pop_front();
          chk("rx_dut_idx", 32'(i), 32'(e.idx));
          chk("rx_data", rxd_of(i), e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  logic [31:0] stream_mo [3];
  logic [31:0] stream_tx [3];

  initial begin
    logic [31:0] mi;
    stream_mo = '{32'h123, 32'hABC, 32'hFFF};
    stream_tx = '{32'h456, 32'h789, 32'h0F0};
    rst = 1'b1;
    sclk_v = 5'b01100;
    ss_v = '0;
    mosi_v = '0;
    tx_valid_v = '0;
    txd = '{default: 8'h00};
    txd4 = '0;
`ifdef SPI_SLAVE_SYNC_STATUS_EN
    status_clr_v = '0;
`endif
    wait_clk(3);
    chk("reset_tx_ready", 32'(tx_ready_v), 32'h1F);
    chk("reset_busy", 32'(busy_v), 32'h0);
    chk("reset_rx_valid", 32'(rx_valid_v), 32'h0);
    chk("reset_miso", 32'(miso_v), 32'h0);
    chk("reset_rx_data", rxd_of(0), 32'h0);
    rst = 1'b0;
    wait_clk(5);

    // mode 0 basic words
    offer(0, 32'h95);
    xfer(0, 32'h6A, 32'h6A, 32'h95, "m0_word1");
    offer(0, 32'h92);
    xfer(0, 32'h91, 32'h91, 32'h92, "m0_word2");

    // nothing queued: all-ones goes out
`ifdef SPI_SLAVE_SYNC_STATUS_EN
    @(negedge clk); status_clr_v[0] = 1'b1;
    @(negedge clk); status_clr_v[0] = 1'b0;
    chk("underrun_cleared", 32'(underrun_v[0]), 32'd0);
`endif
    xfer(0, 32'h33, 32'h33, 32'hFF, "underrun");
`ifdef SPI_SLAVE_SYNC_STATUS_EN
    chk("underrun_set", 32'(underrun_v[0]), 32'd1);
    @(negedge clk); status_clr_v[0] = 1'b1;
    @(negedge clk); status_clr_v[0] = 1'b0;
    chk("underrun_clr", 32'(underrun_v[0]), 32'd0);
`endif

    // ss dropped after 5 bits
    offer(0, 32'h11);
    ss_set(0, 1'b1);
    clock_bits(0, 32'hF0, 5, mi);
    wait_clk(6);
    ss_set(0, 1'b0);
    wait_clk(4);
    chk("abort_rx_hold", rxd_of(0), 32'h33);
`ifdef SPI_SLAVE_SYNC_STATUS_EN
    chk("abort_flag", 32'(abort_v[0]), 32'd1);
`endif
    offer(0, 32'h77);
    xfer(0, 32'h5A, 32'h5A, 32'h77, "after_abort");

    // modes 1..3
    for (int i = 1; i < 4; i++) begin
      offer(i, 32'h3C);
      xfer(i, 32'hA5, 32'hA5, 32'h3C, "mode");
    end

    // WIDTH=12 LSB-first back-to-back stream
    offer(4, stream_tx[0]);
    for (int w = 0; w < 3; w++) exp_q.push_back('{idx: 3'd4, data: stream_mo[w]});
    fork
      begin
        logic [31:0] smi;
        ss_set(4, 1'b1);
        for (int w = 0; w < 3; w++) begin
          clock_bits(4, stream_mo[w], 12, smi);
          chk("w12_stream_miso", smi, stream_tx[w]);
        end
        wait_clk(6);
        ss_set(4, 1'b0);
      end
      begin
        offer(4, stream_tx[1]);
        offer(4, stream_tx[2]);
      end
    join
    wait_clk(4);

    // reset mid-word with ss high
    offer(0, 32'h44);
    ss_set(0, 1'b1);
    clock_bits(0, 32'hFF, 3, mi);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_miso", 32'(miso_v[0]), 32'd0);
    chk("midrst_tx_ready", 32'(tx_ready_v[0]), 32'd1);
    chk("midrst_rx_data", rxd_of(0), 32'h0);
    chk("midrst_rx_valid", 32'(rx_valid_v[0]), 32'd0);
    chk("midrst_busy", 32'(busy_v[0]), 32'd0);
    rst = 1'b0;
    clock_bits(0, 32'hFF, 5, mi);
    wait_clk(6);
    chk("wait_rx_hold", rxd_of(0), 32'h0);
    ss_set(0, 1'b0);
    wait_clk(4);
    offer(0, 32'hB4);
    xfer(0, 32'hC3, 32'hC3, 32'hB4, "post_reset");

    wait_clk(20);
    chk("rx_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
